// File: rtl/id_stage_hz.sv
// Decode stage: IF/ID latch with valid/stall/flush, register file, 16-bit ISA decode, load-use interlock.
// Optional macro ID_WB_BYPASS_EN: register-file read ports forward same-cycle write-back data.
module id_stage_hz #(
    parameter int DATA_W   = 16,
    parameter int PC_W     = 16,
    parameter int NUM_REGS = 16,
    parameter int SP_REG   = 14,
    parameter int LR_REG   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic [PC_W-1:0]   pc_inc_in,
    input  logic [15:0]       instr_in,
    input  logic              wb_we,
    input  logic [3:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_mem_read,
    input  logic [3:0]        ex_dst,
    output logic              valid_out,
    output logic [15:0]       instr_out,
    output logic [PC_W-1:0]   pc_inc_out,
    output logic [PC_W-1:0]   pc_branch,
    output logic [PC_W-1:0]   pc_call,
    output logic [DATA_W-1:0] r0_data,
    output logic [DATA_W-1:0] r1_data,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] offset,
    output logic [3:0]        rs,
    output logic [3:0]        rt,
    output logic [3:0]        rd,
    output logic [2:0]        bcond,
    output logic [19:0]       ctrl,
    output logic              hazard_stall
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_NAND = 4'h2, OP_XOR  = 4'h3,
        OP_INC  = 4'h4, OP_SH5  = 4'h5, OP_SH6  = 4'h6, OP_SH7  = 4'h7,
        OP_LW   = 4'h8, OP_SW   = 4'h9, OP_LHB  = 4'hA, OP_LLB  = 4'hB,
        OP_B    = 4'hC, OP_CALL = 4'hD, OP_RET  = 4'hE, OP_HLT  = 4'hF
    } opcode_t;

    localparam int unsigned NREG = NUM_REGS;

    logic [15:0]       instr_q;
    logic [PC_W-1:0]   pc_q;
    logic              valid_q;
    logic [DATA_W-1:0] regs [0:NUM_REGS-1];

    opcode_t     op;
    logic        rw, mr, m2r, mw, br, cl, rt_ret, ptm, spa, hlt;
    logic [1:0]  alu_src;
    logic [3:0]  alu_op, dst;
    logic [3:0]  r0_idx, r1_idx;
    logic        r0_used, r1_used;
    logic        live;

    assign op = opcode_t'(instr_q[15:12]);

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush_in) begin
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (!(stall_in || hazard_stall)) begin
            instr_q <= instr_in;
            pc_q    <= pc_inc_in;
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_we && (32'(wb_addr) < NREG)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rw = 1'b0; mr = 1'b0; m2r = 1'b0; mw = 1'b0; br = 1'b0;
        cl = 1'b0; rt_ret = 1'b0; ptm = 1'b0; spa = 1'b0; hlt = 1'b0;
        alu_src = 2'b00;
        alu_op  = 4'h0;
        dst     = instr_q[11:8];
        r0_idx  = instr_q[7:4];
        r1_idx  = instr_q[3:0];
        r0_used = 1'b1;
        r1_used = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_NAND, OP_XOR: begin
                rw      = 1'b1;
                alu_op  = instr_q[15:12];
                r1_used = 1'b1;
            end
            OP_INC: alu_src = 2'b01;
            OP_SH5, OP_SH6, OP_SH7: begin
                alu_src = 2'b01;
                alu_op  = instr_q[15:12];
            end
            OP_LW: begin
                rw = 1'b1; mr = 1'b1; m2r = 1'b1;
                alu_src = 2'b01;
                r0_idx  = 4'(SP_REG);
            end
            OP_SW: begin
                mw      = 1'b1;
                alu_src = 2'b01;
                r0_idx  = 4'(SP_REG);
                r1_idx  = instr_q[11:8];
                r1_used = 1'b1;
            end
            OP_LHB, OP_LLB: begin
                rw      = 1'b1;
                alu_src = 2'b10;
                alu_op  = instr_q[15:12];
                r0_idx  = instr_q[11:8];
            end
            OP_B: begin
                br      = 1'b1;
                r0_used = 1'b0;
            end
            OP_CALL: begin
                rw = 1'b1; mw = 1'b1; ptm = 1'b1; spa = 1'b1; cl = 1'b1;
                alu_src = 2'b11;
                alu_op  = 4'h1;
                r0_idx  = 4'(LR_REG);
                dst     = 4'(LR_REG);
                r1_used = 1'b1;
            end
            OP_RET: begin
                rw = 1'b1; mr = 1'b1; rt_ret = 1'b1;
                alu_src = 2'b11;
                r0_idx  = 4'(LR_REG);
                dst     = 4'(LR_REG);
                r1_used = 1'b1;
            end
            OP_HLT: begin
                hlt     = 1'b1;
                r0_used = 1'b0;
            end
            default: ;
        endcase
    end

    // CALL/RET r1 usage is intentionally conservative: an extra stall is harmless
    assign hazard_stall = valid_q && ex_mem_read &&
                          ((r0_used && (r0_idx == ex_dst)) || (r1_used && (r1_idx == ex_dst)));
    assign live      = valid_q && !hazard_stall;
    assign valid_out = live;
    assign ctrl      = live ? {rw, mr, m2r, mw, br, cl, rt_ret, ptm, spa, alu_src, alu_op, dst, hlt}
                            : '0;

    always_comb begin
        r0_data = '0;
        if (32'(r0_idx) < NREG) begin
            r0_data = regs[r0_idx];
`ifdef ID_WB_BYPASS_EN
            if (wb_we && (wb_addr == r0_idx)) r0_data = wb_data;
`endif
        end
    end

    always_comb begin
        r1_data = '0;
        if (32'(r1_idx) < NREG) begin
            r1_data = regs[r1_idx];
`ifdef ID_WB_BYPASS_EN
            if (wb_we && (wb_addr == r1_idx)) r1_data = wb_data;
`endif
        end
    end

    assign instr_out  = instr_q;
    assign pc_inc_out = pc_q;
    assign pc_branch  = pc_q + {{(PC_W-8){instr_q[7]}}, instr_q[7:0]} + PC_W'(1);
    assign imm        = {{(DATA_W-4){instr_q[3]}}, instr_q[3:0]};
    assign offset     = {{(DATA_W-8){instr_q[7]}}, instr_q[7:0]};
    assign rs         = instr_q[7:4];
    assign rt         = instr_q[3:0];
    assign rd         = instr_q[11:8];
    assign bcond      = instr_q[10:8];

    generate
        if (PC_W > 12) begin : g_call_wide
            assign pc_call = {pc_inc_in[PC_W-1:12], instr_q[11:0]};
        end else begin : g_call_narrow
            assign pc_call = instr_q[11:0];
        end
    endgenerate

endmodule

// File: tb/tb_id_stage_hz.sv
// Directed bench for id_stage_hz: decode/hazard vector table plus reset, stall/flush, bypass, CALL and branch sequences.
module tb_id_stage_hz;

    logic        clk = 1'b0;
    logic        rst, stall_in, flush_in, wb_we, ex_mem_read;
    logic [15:0] pc_inc_in, instr_in, wb_data;
    logic [3:0]  wb_addr, ex_dst;
    logic        valid_out, hazard_stall;
    logic [15:0] instr_out, pc_inc_out, pc_branch, pc_call, r0_data, r1_data, imm, offset;
    logic [3:0]  rs, rt, rd;
    logic [2:0]  bcond;
    logic [19:0] ctrl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage_hz #(.DATA_W(16), .PC_W(16), .NUM_REGS(16), .SP_REG(14), .LR_REG(15)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
        .pc_inc_in(pc_inc_in), .instr_in(instr_in),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
        .valid_out(valid_out), .instr_out(instr_out), .pc_inc_out(pc_inc_out),
        .pc_branch(pc_branch), .pc_call(pc_call),
        .r0_data(r0_data), .r1_data(r1_data), .imm(imm), .offset(offset),
        .rs(rs), .rt(rt), .rd(rd), .bcond(bcond), .ctrl(ctrl), .hazard_stall(hazard_stall)
    );

    typedef struct {
        logic [15:0] instr;
        logic        emr;
        logic [3:0]  xdst;
        logic [19:0] exp_ctrl;
        logic        exp_hz;
    } vec_t;

    vec_t vecs[19];

    // flags = {reg_write, mem_read, mem_to_reg, mem_write, branch, call, ret, pc_to_mem, sp_addr}
    function automatic logic [19:0] ctl(input logic [8:0] flags, input logic [1:0] asrc,
                                        input logic [3:0] aop, input logic [3:0] d, input logic h);
        return {flags, asrc, aop, d, h};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0; wb_we = 1'b0; ex_mem_read = 1'b0;
        pc_inc_in = 16'h0000; instr_in = 16'h0123; wb_data = 16'h0000; wb_addr = 4'd0; ex_dst = 4'd0;

        vecs[0]  = '{16'h0312, 1'b0, 4'd0,  ctl(9'b100000000, 2'b00, 4'h0, 4'h3, 1'b0), 1'b0};
        vecs[1]  = '{16'h1345, 1'b1, 4'd7,  ctl(9'b100000000, 2'b00, 4'h1, 4'h3, 1'b0), 1'b0};
        vecs[2]  = '{16'h1345, 1'b1, 4'd5,  20'h0, 1'b1};
        vecs[3]  = '{16'h4520, 1'b1, 4'd0,  ctl(9'b000000000, 2'b01, 4'h0, 4'h5, 1'b0), 1'b0};
        vecs[4]  = '{16'h4520, 1'b1, 4'd2,  20'h0, 1'b1};
        vecs[5]  = '{16'h8A3C, 1'b1, 4'd14, 20'h0, 1'b1};
        vecs[6]  = '{16'h8A3C, 1'b1, 4'd3,  ctl(9'b111000000, 2'b01, 4'h0, 4'hA, 1'b0), 1'b0};
        vecs[7]  = '{16'h9B12, 1'b1, 4'd11, 20'h0, 1'b1};
        vecs[8]  = '{16'h9B12, 1'b0, 4'd0,  ctl(9'b000100000, 2'b01, 4'h0, 4'hB, 1'b0), 1'b0};
        vecs[9]  = '{16'hA712, 1'b1, 4'd1,  ctl(9'b100000000, 2'b10, 4'hA, 4'h7, 1'b0), 1'b0};
        vecs[10] = '{16'hA712, 1'b1, 4'd7,  20'h0, 1'b1};
        vecs[11] = '{16'hC305, 1'b1, 4'd0,  ctl(9'b000010000, 2'b00, 4'h0, 4'h3, 1'b0), 1'b0};
        vecs[12] = '{16'hD456, 1'b1, 4'd6,  20'h0, 1'b1};
        vecs[13] = '{16'hD456, 1'b0, 4'd0,  ctl(9'b100101011, 2'b11, 4'h1, 4'hF, 1'b0), 1'b0};
        vecs[14] = '{16'hE123, 1'b0, 4'd0,  ctl(9'b110000100, 2'b11, 4'h0, 4'hF, 1'b0), 1'b0};
        vecs[15] = '{16'hE123, 1'b1, 4'd15, 20'h0, 1'b1};
        vecs[16] = '{16'h7ABC, 1'b0, 4'd0,  ctl(9'b000000000, 2'b01, 4'h7, 4'hA, 1'b0), 1'b0};
        vecs[17] = '{16'h0312, 1'b1, 4'd2,  20'h0, 1'b1};
        vecs[18] = '{16'h2BCD, 1'b1, 4'd9,  ctl(9'b100000000, 2'b00, 4'h2, 4'hB, 1'b0), 1'b0};

        // reset held two cycles
        tick();
        tick();
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_hazard", 32'(hazard_stall), 32'd0);
        check("rst_instr", 32'(instr_out), 32'd0);
        check("rst_pc", 32'(pc_inc_out), 32'd0);
        check("rst_r0", 32'(r0_data), 32'd0);
        check("rst_r1", 32'(r1_data), 32'd0);
        rst = 1'b0;
        tick();
        check("first_load_instr", 32'(instr_out), 32'h0123);
        check("first_load_valid", 32'(valid_out), 32'd1);

        // decode / hazard table
        for (int i = 0; i < 19; i++) begin
            ex_mem_read = 1'b0;
            instr_in = vecs[i].instr;
            tick();
            ex_mem_read = vecs[i].emr;
            ex_dst = vecs[i].xdst;
            #1;
            check($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
            check($sformatf("vec%0d_hazard", i), 32'(hazard_stall), 32'(vecs[i].exp_hz));
            check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(!vecs[i].exp_hz));
        end
        ex_mem_read = 1'b0;

        // field extraction
        instr_in = 16'h1A9C;
        tick();
        check("imm_sext", 32'(imm), 32'hFFFC);
        check("offset_sext", 32'(offset), 32'hFF9C);
        check("rs", 32'(rs), 32'h9);
        check("rt", 32'(rt), 32'hC);
        check("rd", 32'(rd), 32'hA);
        check("bcond", 32'(bcond), 32'h2);

        // load-use interlock then release
        instr_in = 16'h0312;
        tick();
        ex_mem_read = 1'b1; ex_dst = 4'd1;
        instr_in = 16'h5555;
        #1;
        check("lu_hazard", 32'(hazard_stall), 32'd1);
        check("lu_ctrl", 32'(ctrl), 32'd0);
        tick();
        check("lu_hold", 32'(instr_out), 32'h0312);
        ex_mem_read = 1'b0;
        #1;
        check("lu_release", 32'(hazard_stall), 32'd0);
        check("lu_regwrite", 32'(ctrl[19]), 32'd1);
        check("lu_valid", 32'(valid_out), 32'd1);

        // flush beats stall, then stall alone holds
        stall_in = 1'b1; flush_in = 1'b1;
        tick();
        check("flush_instr", 32'(instr_out), 32'd0);
        check("flush_valid", 32'(valid_out), 32'd0);
        stall_in = 1'b0; flush_in = 1'b0;
        instr_in = 16'h2468;
        tick();
        stall_in = 1'b1;
        instr_in = 16'h1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall_hold%0d", c), 32'(instr_out), 32'h2468);
        end
        check("stall_valid", 32'(valid_out), 32'd1);
        stall_in = 1'b0;

        // write-back bypass on r0 (rs = 3) with r1 (rt = 4) steady
        wb_we = 1'b1; wb_addr = 4'd3; wb_data = 16'h1111;
        tick();
        wb_addr = 4'd4; wb_data = 16'h2222;
        tick();
        wb_we = 1'b0;
        instr_in = 16'h0034;
        tick();
        check("rf_r1", 32'(r1_data), 32'h2222);
        wb_we = 1'b1; wb_addr = 4'd3; wb_data = 16'hBEEF;
        #1;
`ifdef ID_WB_BYPASS_EN
        check("bypass_same_cycle", 32'(r0_data), 32'hBEEF);
`else
        check("bypass_same_cycle", 32'(r0_data), 32'h1111);
`endif
        tick();
        wb_we = 1'b0;
        #1;
        check("bypass_next_cycle", 32'(r0_data), 32'hBEEF);

        // CALL: link register read and pc_call splice
        wb_we = 1'b1; wb_addr = 4'd15; wb_data = 16'hABCD;
        tick();
        wb_we = 1'b0;
        instr_in = 16'hD456; pc_inc_in = 16'h7001;
        tick();
        check("call_pc", 32'(pc_call), 32'h7456);
        check("call_flag", 32'(ctrl[14]), 32'd1);
        check("call_dst", 32'(ctrl[4:1]), 32'hF);
        check("call_r0_lr", 32'(r0_data), 32'hABCD);
        check("call_pc_out", 32'(pc_inc_out), 32'h7001);

        // branch target wrap and negative offset
        instr_in = 16'hC001; pc_inc_in = 16'hFFFF;
        tick();
        check("branch_wrap", 32'(pc_branch), 32'h0001);
        instr_in = 16'hC0FE; pc_inc_in = 16'h0010;
        tick();
        check("branch_neg", 32'(pc_branch), 32'h000F);

        // reset mid-stall and mid-write
        wb_we = 1'b1; wb_addr = 4'd5; wb_data = 16'h5555;
        stall_in = 1'b1; rst = 1'b1;
        tick();
        check("rst2_instr", 32'(instr_out), 32'd0);
        check("rst2_valid", 32'(valid_out), 32'd0);
        rst = 1'b0; wb_we = 1'b0; stall_in = 1'b0;
        instr_in = 16'h0050;
        tick();
        check("rst2_reg5", 32'(r0_data), 32'd0);
        check("rst2_lr", 32'(r1_data), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
